// File: rtl/sw_pkg.sv
// Shared types and sizing for the SW feeder slice.
// Optional feature macro used by sw_seq_feeder: SW_FEEDER_PINGPONG_EN.
package sw_pkg;
    localparam int unsigned REF_LEN   = 64;
    localparam int unsigned QRY_LEN   = 48;
    localparam int unsigned BPW       = 4;
    localparam int unsigned REF_WORDS = REF_LEN / BPW;
    localparam int unsigned QRY_WORDS = QRY_LEN / BPW;
    localparam int unsigned JOB_WORDS = REF_WORDS + QRY_WORDS;

    localparam int unsigned WCNT_W = 5;
    localparam int unsigned BCNT_W = 6;
    localparam int unsigned BPW_LG = $clog2(BPW);
    localparam int unsigned RW_W   = $clog2(REF_WORDS);
    localparam int unsigned QW_W   = $clog2(QRY_WORDS);

    typedef logic [1:0]        base_t;
    typedef logic [2*BPW-1:0]  word_t;
    typedef logic [WCNT_W-1:0] wcnt_t;
    typedef logic [BCNT_W-1:0] bcnt_t;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_STREAM,
        ST_WAIT_FIN
    } feed_state_t;
endpackage

// File: rtl/sw_job_buf.sv
// One job's worth of ref/query bases: word-wide write port, single-base read port.
module sw_job_buf
    import sw_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  wr_en,
    input  wcnt_t wr_idx,
    input  word_t wr_data,
    input  bcnt_t rd_idx,
    output base_t rd_ref,
    output base_t rd_qry
);
    word_t ref_w [REF_WORDS];
    word_t qry_w [QRY_WORDS];
    logic [QW_W-1:0] qw_idx;
    word_t ref_word;
    word_t qry_word;

    assign qw_idx = QW_W'(wr_idx - wcnt_t'(REF_WORDS));

    always_ff @(posedge clk) begin
        if (reset) begin
            ref_w <= '{default: '0};
            qry_w <= '{default: '0};
        end else if (wr_en) begin
            if (wr_idx < wcnt_t'(REF_WORDS))
                ref_w[wr_idx[RW_W-1:0]] <= wr_data;
            else
                qry_w[qw_idx] <= wr_data;
        end
    end

    // Query is shorter than ref; beats past its end read as base 0.
    always_comb begin
        ref_word = ref_w[rd_idx[BCNT_W-1:BPW_LG]];
        qry_word = '0;
        if (rd_idx < bcnt_t'(QRY_LEN))
            qry_word = qry_w[rd_idx[BCNT_W-1:BPW_LG]];
        rd_ref = ref_word[{rd_idx[BPW_LG-1:0], 1'b0} +: 2];
        rd_qry = qry_word[{rd_idx[BPW_LG-1:0], 1'b0} +: 2];
    end
endmodule

// File: rtl/sw_seq_feeder.sv
// Loads one ref+query job from the host stream, replays it as a 64-beat burst to SW.
// Define SW_FEEDER_PINGPONG_EN for two job buffers (load next job while current streams).
module sw_seq_feeder
    import sw_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*BPW-1:0] in_data,
    input  logic           in_last,
    output logic           sw_valid,
    output logic [1:0]     sw_ref,
    output logic [1:0]     sw_query,
    input  logic           sw_finish,
    output logic           busy,
    output logic           proto_err
);
    feed_state_t state, state_nxt;
    wcnt_t wcnt;
    bcnt_t bcnt;
    bcnt_t rd_idx;
    base_t rd_ref, rd_qry;
    logic  accept, last_word, done, bad, pending, start;

    assign accept    = in_valid & in_ready;
    assign last_word = (wcnt == wcnt_t'(JOB_WORDS - 1));
    assign done      = accept & in_last & last_word;
    assign bad       = accept & (in_last ^ last_word);
    // Outputs are registered, so the buffer is read one beat ahead.
    assign rd_idx    = (state == ST_STREAM) ? bcnt + 1'b1 : '0;
    assign start     = ((state == ST_LOAD) || (state == ST_WAIT_FIN && sw_finish))
                       && (pending || done);

`ifdef SW_FEEDER_PINGPONG_EN
    logic  wr_sel, rd_sel, rd_buf;
    base_t ref0, qry0, ref1, qry1;

    assign in_ready = ~pending;
    assign busy     = (state != ST_LOAD) | pending;
    // rd_sel retires on finish; a burst starting on that same edge reads the other buffer.
    assign rd_buf   = (state == ST_WAIT_FIN && sw_finish) ? ~rd_sel : rd_sel;
    assign rd_ref   = rd_buf ? ref1 : ref0;
    assign rd_qry   = rd_buf ? qry1 : qry0;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_sel  <= 1'b0;
            rd_sel  <= 1'b0;
            pending <= 1'b0;
        end else begin
            if (done)
                wr_sel <= ~wr_sel;
            if (state == ST_WAIT_FIN && sw_finish)
                rd_sel <= ~rd_sel;
            pending <= start ? 1'b0 : (pending | done);
        end
    end

    sw_job_buf u_buf0 (
        .clk(clk), .reset(reset), .wr_en(accept & ~wr_sel), .wr_idx(wcnt), .wr_data(in_data),
        .rd_idx(rd_idx), .rd_ref(ref0), .rd_qry(qry0)
    );
    sw_job_buf u_buf1 (
        .clk(clk), .reset(reset), .wr_en(accept & wr_sel), .wr_idx(wcnt), .wr_data(in_data),
        .rd_idx(rd_idx), .rd_ref(ref1), .rd_qry(qry1)
    );
`else
    assign pending  = 1'b0;
    assign in_ready = (state == ST_LOAD);
    assign busy     = (state != ST_LOAD);

    sw_job_buf u_buf (
        .clk(clk), .reset(reset), .wr_en(accept), .wr_idx(wcnt), .wr_data(in_data),
        .rd_idx(rd_idx), .rd_ref(rd_ref), .rd_qry(rd_qry)
    );
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_LOAD;
            wcnt      <= '0;
            bcnt      <= '0;
            sw_valid  <= 1'b0;
            sw_ref    <= '0;
            sw_query  <= '0;
            proto_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            proto_err <= bad;
            if (accept)
                wcnt <= (done | bad) ? '0 : wcnt + 1'b1;
            bcnt <= (state == ST_STREAM) ? bcnt + 1'b1 : '0;
            if (start || (state == ST_STREAM && bcnt != '1)) begin
                sw_valid <= 1'b1;
                sw_ref   <= rd_ref;
                sw_query <= rd_qry;
            end else begin
                sw_valid <= 1'b0;
                sw_ref   <= '0;
                sw_query <= '0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_LOAD:     if (start) state_nxt = ST_STREAM;
            ST_STREAM:   if (bcnt == '1) state_nxt = ST_WAIT_FIN;
            ST_WAIT_FIN: if (sw_finish) state_nxt = start ? ST_STREAM : ST_LOAD;
            default:     state_nxt = ST_LOAD;
        endcase
    end
endmodule

// File: tb/tb_sw_seq_feeder.sv
// Randomized bench for sw_seq_feeder against a job-queue reference model.
// Covers the ping-pong scenario too when SW_FEEDER_PINGPONG_EN is defined.
module tb_sw_seq_feeder;
    import sw_pkg::*;

`ifdef SW_FEEDER_PINGPONG_EN
    localparam bit PP = 1'b1;
`else
    localparam bit PP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       sw_finish = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_ready, sw_valid, busy, proto_err;
    logic [1:0] sw_ref, sw_query;

    sw_seq_feeder dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .sw_valid(sw_valid), .sw_ref(sw_ref),
        .sw_query(sw_query), .sw_finish(sw_finish), .busy(busy), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    // A job as the host sees it: base k of ref at r[2k+:2], base k of query at q[2k+:2].
    typedef struct packed {
        logic [127:0] r;
        logic [95:0]  q;
    } job_t;

    job_t ld;
    job_t exp_q[$];
    int   n_checks = 0;
    int   n_pass = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // mode 0: ref all 01 / query all 10; 1: ref k%4, query random; 2: all random
    task automatic make_job(input int mode);
        for (int k = 0; k < 64; k++)
            ld.r[2*k +: 2] = (mode == 0) ? 2'b01 : (mode == 1) ? 2'(k % 4) : 2'($urandom);
        for (int k = 0; k < 48; k++)
            ld.q[2*k +: 2] = (mode == 0) ? 2'b10 : 2'($urandom);
    endtask

    task automatic send_job(input int last_at, input int n_words, input int gap_pct);
        for (int w = 0; w < n_words; w++) begin
            while (int'($urandom_range(99)) < gap_pct) begin
                in_valid = 1'b0;
                tick;
            end
            in_valid = 1'b1;
            in_data  = (w < 16) ? 8'(ld.r >> (w * 8)) : 8'(ld.q >> ((w - 16) * 8));
            in_last  = (w == last_at);
            for (int t = 0; t < 200 && !in_ready; t++) tick;
            check_eq($sformatf("in_ready_w%0d", w), 32'(in_ready), 1);
            tick;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (last_at == 27 && n_words == 28) exp_q.push_back(ld);
    endtask

    task automatic check_stream(input int nbeats, input int early_fin);
        job_t e;
        logic [4:0] expv;
        if (exp_q.size() == 0) begin
            check_eq("job_queued", 0, 1);
            return;
        end
        e = exp_q.pop_front();
        for (int b = 0; b < nbeats; b++) begin
            expv = {1'b1, 2'(e.r >> (2 * b)), (b < 48) ? 2'(e.q >> (2 * b)) : 2'b00};
            check_eq($sformatf("beat%0d", b), 32'({sw_valid, sw_ref, sw_query}), 32'(expv));
            sw_finish = (b == early_fin);
            tick;
        end
        sw_finish = 1'b0;
        if (nbeats == 64) begin
            check_eq("post_outputs", 32'({sw_valid, sw_ref, sw_query}), 0);
            check_eq("post_busy", 32'(busy), 1);
        end
    endtask

    task automatic finish_job(input int delay);
        for (int i = 0; i < delay; i++) begin
            check_eq("wait_valid", 32'(sw_valid), 0);
            tick;
        end
        check_eq("wait_in_ready", 32'(in_ready), 32'(PP));
        sw_finish = 1'b1;
        tick;
        sw_finish = 1'b0;
        check_eq("fin_in_ready", 32'(in_ready), 1);
        check_eq("fin_busy", 32'(busy), 0);
    endtask

    initial begin
        repeat (3) tick;
        check_eq("rst_in_ready", 32'(in_ready), 1);
        check_eq("rst_outputs", 32'({sw_valid, sw_ref, sw_query}), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_proto_err", 32'(proto_err), 0);
        reset = 1'b0;
        tick;

        // Constant pattern, back-to-back words
        make_job(0);
        send_job(27, 28, 0);
        check_stream(64, -1);
        finish_job(3);

        // k%4 ref with input gaps; early finish mid-stream and on the last beat
        make_job(1);
        send_job(27, 28, 30);
        check_stream(64, 10);
        finish_job(2);
        make_job(2);
        send_job(27, 28, 15);
        check_stream(64, 63);
        finish_job(0);

        // Misplaced in_last, then missing in_last, then a clean job
        make_job(2);
        send_job(5, 6, 20);
        check_eq("perr_early", 32'(proto_err), 1);
        check_eq("perr_early_valid", 32'(sw_valid), 0);
        check_eq("perr_early_busy", 32'(busy), 0);
        tick;
        check_eq("perr_early_pulse", 32'(proto_err), 0);
        check_eq("perr_early_novalid", 32'(sw_valid), 0);
        send_job(-1, 28, 0);
        check_eq("perr_missing", 32'(proto_err), 1);
        check_eq("perr_missing_valid", 32'(sw_valid), 0);
        tick;
        check_eq("perr_missing_pulse", 32'(proto_err), 0);
        make_job(2);
        send_job(27, 28, 10);
        check_eq("clean_perr", 32'(proto_err), 0);
        check_stream(64, -1);
        finish_job(1);

        // Reset while beat 30 is on the bus
        make_job(2);
        send_job(27, 28, 0);
        check_stream(30, -1);
        reset = 1'b1;
        tick;
        check_eq("midrst_valid", 32'(sw_valid), 0);
        check_eq("midrst_in_ready", 32'(in_ready), 1);
        check_eq("midrst_busy", 32'(busy), 0);
        reset = 1'b0;
        tick;

        for (int j = 0; j < 3; j++) begin
            make_job(2);
            send_job(27, 28, 25);
            check_stream(64, int'($urandom_range(70)));
            finish_job(int'($urandom_range(4)));
        end

`ifdef SW_FEEDER_PINGPONG_EN
        // Second job loads during the first burst and streams right after finish
        make_job(2);
        send_job(27, 28, 0);
        fork
            check_stream(64, -1);
            begin
                make_job(2);
                send_job(27, 28, 0);
            end
        join
        check_eq("pp_pending_ready", 32'(in_ready), 0);
        check_eq("pp_pending_busy", 32'(busy), 1);
        sw_finish = 1'b1;
        tick;
        sw_finish = 1'b0;
        check_stream(64, -1);
        finish_job(1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
